// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state encoding and latency derivation for the FFT sequencer
package fft_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    function automatic int calc_lat(input int rd_lat, input int bfly_lat);
        return rd_lat + bfly_lat;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: registered butterfly pair and twiddle index for stage s, butterfly j
module fft_addr_gen #(
    parameter int LOG2_SIZE  = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            s,
    input  logic [ADDR_WIDTH-1:0] j,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [ADDR_WIDTH-1:0] addrb,
    output logic [ADDR_WIDTH-2:0] tw_addr
);
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0] a;

    // group index goes above the span bit, offset within the group stays below it
    always_comb begin
        span = ADDR_WIDTH'(1) << s;
        k    = j & (span - ADDR_WIDTH'(1));
        a    = ((j >> s) << (s + 4'd1)) | k;
    end

    // one register stage so addresses line up with the registered read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            addra   <= '0;
            addrb   <= '0;
            tw_addr <= '0;
        end else begin
            addra   <= a;
            addrb   <= a + span;
            tw_addr <= (ADDR_WIDTH-1)'(k << (4'(LOG2_SIZE - 1) - s));
        end
    end
endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: sequences an in-place radix-2 DIT FFT, delaying write-side controls to butterfly output
module fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_SIZE       = 4096,
    parameter int LOG2_SIZE      = 12,
    parameter int ADDR_WIDTH     = 12,
    parameter int MEM_RD_LATENCY = 1,
    parameter int BFLY_LATENCY   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addra,
    output logic [ADDR_WIDTH-1:0] rd_addrb,
    output logic [ADDR_WIDTH-2:0] tw_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addra,
    output logic [ADDR_WIDTH-1:0] wr_addrb,
    output logic                  scale,
    output logic [3:0]            stage
);
    localparam int LAT  = calc_lat(MEM_RD_LATENCY, BFLY_LATENCY);
    localparam int HALF = FFT_SIZE / 2;
    localparam int CW   = $clog2(LAT + 1);
    localparam int PW   = 2 * ADDR_WIDTH + 2;

    state_t                   state;
    logic [3:0]               s;
    logic [ADDR_WIDTH-1:0]    j;
    logic [CW-1:0]            dcnt;
    logic [3:0]               ag_s;
    logic [LAT-1:0][PW-1:0]   pipe;

    // j counts one ahead of the presented read; during drain the generator is pre-loaded with the next stage
    always_comb ag_s = (state == ST_DRAIN && s != 4'(LOG2_SIZE - 1)) ? s + 4'd1 : s;

    fft_addr_gen #(.LOG2_SIZE(LOG2_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .s       (ag_s),
        .j       (j),
        .addra   (rd_addra),
        .addrb   (rd_addrb),
        .tw_addr (tw_addr)
    );

    // transform sequencer: stage runs, inter-stage drain, completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            s     <= '0;
            j     <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state <= ST_RUN;
                    busy  <= 1'b1;
                    rd_en <= 1'b1;
                    j     <= ADDR_WIDTH'(1);
                end
                ST_RUN: if (j == ADDR_WIDTH'(HALF)) begin
                    state <= ST_DRAIN;
                    rd_en <= 1'b0;
                    j     <= '0;
                    dcnt  <= CW'(LAT - 1);
                end else begin
                    j <= j + ADDR_WIDTH'(1);
                end
                ST_DRAIN: if (dcnt != '0) begin
                    dcnt <= dcnt - CW'(1);
                end else if (s == 4'(LOG2_SIZE - 1)) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_RUN;
                    rd_en <= 1'b1;
                    s     <= s + 4'd1;
                    j     <= ADDR_WIDTH'(1);
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    s     <= '0;
                end
            endcase
        end
    end

    // read-side controls and odd-stage scale travel LAT cycles to meet the butterfly output
    always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= (LAT*PW)'({pipe, rd_addra, rd_addrb, rd_en, s[0]});
    end

    assign {wr_addra, wr_addrb, wr_en, scale} = pipe[LAT-1];
    assign stage = s;
endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
- Sequences one in-place radix-2 decimation-in-time FFT over the sample RAM, driving the butterfly datapath.
- Input samples are already bit-reversed in RAM.
- Per stage it issues butterfly read addresses, twiddle ROM addresses and the per-stage scale flag.
- It delays write addresses, write enable and scale to match memory plus butterfly latency, drains between stages, and pulses done.

Parameters:
- FFT_SIZE, 4096, points per transform (power of 2, >=4)
- LOG2_SIZE, 12, log2(FFT_SIZE) = number of stages
- ADDR_WIDTH, 12, sample RAM address width (= LOG2_SIZE)
- MEM_RD_LATENCY, 1, cycles from rd_addr to RAM/ROM data
- BFLY_LATENCY, 5, cycles from butterfly input to butterfly output

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin transform; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at completion
- rd_en  output  1  read strobe for both RAM ports and the twiddle ROM
- rd_addra  output  ADDR_WIDTH  top butterfly input address
- rd_addrb  output  ADDR_WIDTH  bottom butterfly input address
- tw_addr  output  ADDR_WIDTH-1  twiddle ROM index (N/2 entries)
- wr_en  output  1  write strobe, aligned with butterfly outputs
- wr_addra  output  ADDR_WIDTH  write address for fft_wdataa
- wr_addrb  output  ADDR_WIDTH  write address for fft_wdatab
- scale  output  1  butterfly scale control, aligned with butterfly outputs
- stage  output  4  current stage index (debug/status)

Behaviour:
- Reset is synchronous and active-high, on the single clock clk. On reset all outputs are 0, FSM goes to IDLE, counters clear and all delay-pipe valid bits clear. Reset mid-transform aborts immediately, with no further wr_en. RAM contents are then undefined.
- LAT = MEM_RD_LATENCY + BFLY_LATENCY (6 by default).
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, s=0, j=0, busy=1.
- RUN: rd_en=1 every cycle, j increments. When j = N/2-1: -> DRAIN, drain counter = LAT.
- DRAIN: rd_en=0; count down LAT cycles.
  - At 0, if s = LOG2_SIZE-1 -> DONE.
  - Otherwise s++, j=0 -> RUN.
  - The drain guarantees the last write of stage s lands before the first read of stage s+1.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- start in any state other than IDLE is ignored.
- Address generation (registered; rd_* valid in the same cycle as rd_en):
  - span = 1<<s; k = j & (span-1); grp = j >> s.
  - rd_addra = (grp << (s+1)) | k; rd_addrb = rd_addra + span.
  - tw_addr = k << (LOG2_SIZE-1-s).
- Stage scale bit = s[0], i.e. shift on odd stages: LOG2_SIZE/2 shifts in total, giving overall 1/sqrt(N).
- {rd_addra, rd_addrb, rd_en, scale_bit} enter a LAT-deep shift register whose output drives {wr_addra, wr_addrb, wr_en, scale}. Hence wr_en lags rd_en by exactly LAT cycles.
- scale is combinational into the butterfly output, so it must track the delayed stage, not the current one.
- Timing, with the start cycle = 0:
  - Stage s runs in cycles 1 + s*(N/2+LAT) through (s+1)*(N/2+LAT).
  - done is high in cycle LOG2_SIZE*(N/2+LAT)+1. For N=4096 this is cycle 24649.
- Reads and writes never target the same address in the same cycle within a stage (in-place, disjoint pairs). No bypass is needed.

Decomposition:
- Add to fft_defs.vh: FFT_CTRL state encodings and the LAT constant derivation.
- One sub-module: fft_addr_gen (inputs s, j; outputs addra, addrb, tw_addr; one register stage). The FSM and delay pipe stay in fft_ctrl.

Test Plan:
- FFT_SIZE=8, LOG2_SIZE=3, start pulse: check read pairs and twiddles per stage.
  - Stage 0 reads (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0.
  - Stage 1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2.
  - Stage 2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3.
- Same config: wr_en/wr_addr* equal rd_en/rd_addr* delayed exactly 6 cycles. scale=0 on stage 0/2 writes and 1 on stage 1 writes. done pulses in cycle 31, busy high cycles 1..30.
- start held high throughout and re-pulsed mid-transform: no restart. A single done in cycle 31. A new transform begins only on start sampled in IDLE after DONE.
- rst asserted in cycle 12 (stage 1 RUN): next cycle all outputs 0, no wr_en for 10 subsequent cycles. A fresh start then reproduces the first scenario exactly.
- N=4096 with a behavioural RAM, butterfly and ROM, impulse at bit-reversed index 0: output flat with each bin = input/64. done in cycle 24649.
- Assertions across all runs:
  - rd_addrb - rd_addra = 1<<s.
  - No read of an address with a pending write from a previous stage.
